// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and data ports.
// One access in flight at a time; the RESP cycle re-arbitrates so bursts alternate back-to-back.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_ce,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              m_ce,
    output logic              m_we,
    output logic [3:0]        m_sel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              stall_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;      // 1 = data port owns the access in flight
    logic        last_data;  // 1 = most recent grant went to the data port
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    logic        req_i;
    logic        req_d;
    logic        grant;
    logic        grant_d;

    always_comb begin
        req_i      = 1'b0;
        req_d      = 1'b0;
        grant_d    = 1'b0;
        state_next = state;

        // In RESP the current owner still holds ce high, so it is masked out.
        case (state)
            IDLE: begin
                req_i = i_ce;
                req_d = d_ce;
            end
            RESP: begin
                req_i = i_ce & owner;
                req_d = d_ce & ~owner;
            end
            default: ;
        endcase

        grant = req_i | req_d;
        if (req_i && req_d) begin
            grant_d = DATA_PRIO ? 1'b1 : ~last_data;
        end else begin
            grant_d = req_d;
        end

        case (state)
            IDLE:    state_next = grant ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = grant ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_data <= 1'b0;
            m_ce      <= 1'b0;
            m_we      <= 1'b0;
            m_sel     <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_next;

            if (state == RESP) begin
                if (owner) begin
                    d_rdata_q <= m_rdata;
                end else begin
                    i_rdata_q <= m_rdata;
                end
            end

            if (grant) begin
                owner     <= grant_d;
                last_data <= grant_d;
                m_ce      <= 1'b1;
                if (grant_d) begin
                    m_we    <= d_we;
                    m_sel   <= d_sel;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    m_we   <= 1'b0;
                    m_sel  <= '1;
                    m_addr <= i_addr;
                end
            end else begin
                m_ce <= 1'b0;
                m_we <= 1'b0;
            end
        end
    end

    assign i_ready = (state == RESP) && !owner;
    assign d_ready = (state == RESP) && owner;

    // Pass memory data straight through during RESP, then hold the captured copy.
    assign i_rdata = i_ready ? m_rdata : i_rdata_q;
    assign d_rdata = d_ready ? m_rdata : d_rdata_q;

    assign stall_o = (i_ce & ~i_ready) | (d_ce & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one data-priority and one round-robin instance
// share the same request stimulus, each with its own byte-lane memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_ce;
    logic [31:0] i_addr;
    logic        d_ce;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0, m_rdata0;
    logic        i_ready0, d_ready0, m_ce0, m_we0, stall0;
    logic [3:0]  m_sel0;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic        i_ready1, d_ready1, m_ce1, m_we1, stall1;
    logic [3:0]  m_sel1;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(32), .DATA_PRIO(1'b1)) dut0 (
        .clk(clk), .rst(rst),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata0), .i_ready(i_ready0),
        .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata0), .d_ready(d_ready0),
        .m_ce(m_ce0), .m_we(m_we0), .m_sel(m_sel0), .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_rdata(m_rdata0), .stall_o(stall0)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_PRIO(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .m_ce(m_ce1), .m_we(m_we1), .m_sel(m_sel1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .stall_o(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read as a fixed seed: word 4 (byte 0x10) holds an instruction.
    function automatic logic [31:0] seed(input logic [5:0] idx);
        return (idx == 6'd4) ? 32'h3C01_0001 : (32'h5500_0000 | 32'(idx));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    logic [31:0] wr0 [logic [5:0]];
    logic [31:0] wr1 [logic [5:0]];
    logic [31:0] word0, word1;

    always @(posedge clk) begin
        if (m_ce0) begin
            word0 = wr0.exists(m_addr0[7:2]) ? wr0[m_addr0[7:2]] : seed(m_addr0[7:2]);
            m_rdata0 <= word0;
            if (m_we0) wr0[m_addr0[7:2]] = merge(word0, m_wdata0, m_sel0);
        end
    end

    always @(posedge clk) begin
        if (m_ce1) begin
            word1 = wr1.exists(m_addr1[7:2]) ? wr1[m_addr1[7:2]] : seed(m_addr1[7:2]);
            m_rdata1 <= word1;
            if (m_we1) wr1[m_addr1[7:2]] = merge(word1, m_wdata1, m_sel1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        i_ce    = 1'b1;
        d_ce    = 1'b1;
        i_addr  = 32'h14;
        d_addr  = 32'h20;
        d_we    = 1'b0;
        d_sel   = 4'hF;
        d_wdata = 32'h0;

        // reset held two cycles with both requests high
        tick; #1;
        chk("rst_mce", 32'(m_ce0), 32'd0);
        chk("rst_mwe", 32'(m_we0), 32'd0);
        chk("rst_iready", 32'(i_ready0), 32'd0);
        chk("rst_dready", 32'(d_ready0), 32'd0);
        chk("rst_maddr", m_addr0, 32'h0);
        chk("rst_msel", 32'(m_sel0), 32'h0);
        chk("rst_mwdata", m_wdata0, 32'h0);
        chk("rst_irdata", i_rdata0, 32'h0);
        chk("rst_drdata", d_rdata0, 32'h0);
        chk("rst_stall", 32'(stall0), 32'd1);
        tick; #1;
        chk("rst2_mce", 32'(m_ce0), 32'd0);
        chk("rst2_stall", 32'(stall0), 32'd1);
        rst = 1'b0;

        // contention, data priority: data first, fetch two cycles later
        tick; #1;
        chk("ct_acc_mce", 32'(m_ce0), 32'd1);
        chk("ct_acc_maddr", m_addr0, 32'h20);
        chk("ct_acc_mwe", 32'(m_we0), 32'd0);
        chk("ct_acc_dready", 32'(d_ready0), 32'd0);
        chk("ct_acc_stall", 32'(stall0), 32'd1);
        tick; #1;
        chk("ct_resp_dready", 32'(d_ready0), 32'd1);
        chk("ct_resp_drdata", d_rdata0, 32'h5500_0008);
        chk("ct_resp_iready", 32'(i_ready0), 32'd0);
        chk("ct_resp_mce", 32'(m_ce0), 32'd0);
        chk("ct_resp_stall", 32'(stall0), 32'd1);
        tick; d_ce = 1'b0; #1;
        chk("ct_facc_mce", 32'(m_ce0), 32'd1);
        chk("ct_facc_maddr", m_addr0, 32'h14);
        chk("ct_facc_msel", 32'(m_sel0), 32'hF);
        chk("ct_facc_dready", 32'(d_ready0), 32'd0);
        chk("ct_facc_drdata_hold", d_rdata0, 32'h5500_0008);
        tick; #1;
        chk("ct_fresp_iready", 32'(i_ready0), 32'd1);
        chk("ct_fresp_irdata", i_rdata0, 32'h5500_0005);
        chk("ct_fresp_stall", 32'(stall0), 32'd0);
        tick; i_ce = 1'b0; #1;
        chk("ct_idle_iready", 32'(i_ready0), 32'd0);
        chk("ct_idle_mce", 32'(m_ce0), 32'd0);
        chk("ct_idle_irdata_hold", i_rdata0, 32'h5500_0005);

        // single fetch from 0x10
        tick; i_ce = 1'b1; i_addr = 32'h10; #1;
        chk("sf_n_stall", 32'(stall0), 32'd1);
        chk("sf_n_mce", 32'(m_ce0), 32'd0);
        tick; #1;
        chk("sf_n1_mce", 32'(m_ce0), 32'd1);
        chk("sf_n1_maddr", m_addr0, 32'h10);
        chk("sf_n1_msel", 32'(m_sel0), 32'hF);
        chk("sf_n1_stall", 32'(stall0), 32'd1);
        tick; #1;
        chk("sf_n2_iready", 32'(i_ready0), 32'd1);
        chk("sf_n2_irdata", i_rdata0, 32'h3C01_0001);
        chk("sf_n2_stall", 32'(stall0), 32'd0);
        tick; i_ce = 1'b0; #1;
        chk("sf_n3_iready", 32'(i_ready0), 32'd0);

        // halfword store to 0x40; request fields change after the grant
        tick; d_ce = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h40; d_wdata = 32'hAABB_CCDD; #1;
        chk("st_n_stall", 32'(stall0), 32'd1);
        tick; d_addr = 32'h44; d_wdata = 32'h0; #1;
        chk("st_mce", 32'(m_ce0), 32'd1);
        chk("st_mwe", 32'(m_we0), 32'd1);
        chk("st_msel", 32'(m_sel0), 32'h3);
        chk("st_maddr", m_addr0, 32'h40);
        chk("st_mwdata", m_wdata0, 32'hAABB_CCDD);
        tick; #1;
        chk("st_dready", 32'(d_ready0), 32'd1);
        chk("st_resp_mwe", 32'(m_we0), 32'd0);
        chk("st_resp_stall", 32'(stall0), 32'd0);
        tick; d_ce = 1'b0; d_we = 1'b0; #1;

        // load back 0x40: only the two low lanes were written
        tick; d_ce = 1'b1; d_sel = 4'hF; d_addr = 32'h40; #1;
        tick; #1;
        chk("ld_mwe", 32'(m_we0), 32'd0);
        chk("ld_maddr", m_addr0, 32'h40);
        tick; #1;
        chk("ld_dready", 32'(d_ready0), 32'd1);
        chk("ld_drdata", d_rdata0, 32'h5500_CCDD);
        tick; d_ce = 1'b0; #1;
        chk("ld_idle_dready", 32'(d_ready0), 32'd0);

        // reset during the ACCESS cycle of a store
        tick; d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'h1234_5678; #1;
        tick; rst = 1'b1; #1;
        chk("rs_acc_mwe", 32'(m_we0), 32'd1);
        chk("rs_acc_maddr", m_addr0, 32'h48);
        tick; rst = 1'b0; d_ce = 1'b0; d_we = 1'b0; #1;
        chk("rs_dready", 32'(d_ready0), 32'd0);
        chk("rs_mce", 32'(m_ce0), 32'd0);
        chk("rs_mwe", 32'(m_we0), 32'd0);
        chk("rs_maddr", m_addr0, 32'h0);
        tick; #1;
        chk("rs_idle_mce", 32'(m_ce0), 32'd0);
        chk("rs_idle_dready", 32'(d_ready0), 32'd0);
        tick; d_ce = 1'b1; #1;
        tick; #1;
        tick; #1;
        chk("rs_ld_dready", 32'(d_ready0), 32'd1);
        chk("rs_ld_drdata", d_rdata0, 32'h1234_5678);
        tick; d_ce = 1'b0; #1;

        // tie from IDLE after a data grant: priority picks data, round-robin picks fetch
        tick; i_ce = 1'b1; i_addr = 32'h10; d_ce = 1'b1; d_addr = 32'h20; #1;
        tick; #1;
        chk("tie_p_maddr", m_addr0, 32'h20);
        chk("tie_rr_maddr", m_addr1, 32'h10);
        chk("tie_rr_msel", 32'(m_sel1), 32'hF);
        tick; #1;
        chk("tie_p_dready", 32'(d_ready0), 32'd1);
        chk("tie_rr_iready", 32'(i_ready1), 32'd1);
        chk("tie_rr_irdata", i_rdata1, 32'h3C01_0001);
        tick; #1;
        tick; #1;
        chk("tie_p_iready", 32'(i_ready0), 32'd1);
        chk("tie_rr_dready", 32'(d_ready1), 32'd1);
        i_ce = 1'b0; d_ce = 1'b0;

        // round-robin burst after reset: 8 accesses alternating, data first
        tick; rst = 1'b1; #1;
        tick; rst = 0; i_ce = 1'b1; d_ce = 1'b1; #1;
        for (int k = 1; k <= 8; k++) begin
            tick; #1;
            chk($sformatf("rr_acc%0d_mce", k), 32'(m_ce1), 32'd1);
            tick; #1;
            chk($sformatf("rr_resp%0d_dready", k), 32'(d_ready1), 32'(k % 2));
            chk($sformatf("rr_resp%0d_iready", k), 32'(i_ready1), 32'((k + 1) % 2));
            if (k == 1) begin
                chk("rr_resp1_drdata", d_rdata1, 32'h5500_0008);
                chk("rr_resp1_stall", 32'(stall1), 32'd1);
            end
            if (k == 8) begin
                i_ce = 1'b0;
                d_ce = 1'b0;
            end
        end
        tick; #1;
        chk("rr_end_mce", 32'(m_ce1), 32'd0);
        chk("rr_end_stall", 32'(stall1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port synchronous memory between the CPU instruction-fetch port and the CPU data (load/store) port, so a unified instruction/data RAM can replace the separate ROM and RAM in the SOPC top. Sits between `MipsCPU` and the memory. Each requester raises a held request. The arbiter grants one requester at a time, drives the memory, returns read data with a one-cycle `ready` pulse, and raises a pipeline stall while any request is outstanding.

## Interface
- `ADDR_W`, 32, address width for both requester ports and the memory port
- `DATA_PRIO`, 1, 1 = data port always wins a conflict; 0 = round-robin between the two ports

Ports:
- `clk`  in  1  system clock, all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `i_ce`  in  1  instruction-fetch request, held until `i_ready`
- `i_addr`  in  ADDR_W  fetch byte address
- `i_rdata`  out  32  fetched word, valid while `i_ready`=1
- `i_ready`  out  1  one-cycle completion pulse for the fetch port
- `d_ce`  in  1  data request, held until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_sel`  in  4  byte-lane enables for the access
- `d_addr`  in  ADDR_W  data byte address
- `d_wdata`  in  32  store data
- `d_rdata`  out  32  load data, valid while `d_ready`=1
- `d_ready`  out  1  one-cycle completion pulse for the data port
- `m_ce`, `m_we`  out  1 each  memory enable and write enable (registered)
- `m_sel`  out  4  memory byte lanes (registered)
- `m_addr`  out  ADDR_W  memory address (registered)
- `m_wdata`  out  32  memory write data (registered)
- `m_rdata`  in  32  memory read data, valid the cycle after `m_ce`
- `stall_o`  out  1  pipeline stall request

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - Arbitrate over pending requests.
  - On a grant: latch the winner's addr/we/sel/wdata into the `m_*` registers, set `m_ce`=1, record the owner, go to ACCESS.
  - With no request: stay in IDLE.
- Fetch grants drive `m_we`=0 and `m_sel`=4'b1111.
- ACCESS
  - Memory is driven for exactly one cycle.
  - Always go to RESP; `m_ce` and `m_we` clear at this edge unless the RESP arbitration below re-grants.
- RESP
  - Assert the owner's `ready`.
  - Drive the owner's `rdata` from `m_rdata` and hold it in a register so `rdata` stays stable afterwards.
  - Stores also pulse `ready`; their `d_rdata` is don't-care.
  - Arbitrate again in the same cycle, excluding the current owner, whose `ce` is still high.
  - Grant → ACCESS, back-to-back; no grant → IDLE.
- Arbitration when both ports request:
  - `DATA_PRIO`=1: data wins.
  - `DATA_PRIO`=0: the port not granted last wins. The last-grant flag resets to "fetch", so data wins the first tie.
- `stall_o = (i_ce & ~i_ready) | (d_ce & ~d_ready)`, combinational.
- Requests are latched at grant. Changing addr/data after grant has no effect on the access in flight.
- A requester that drops `ce` before `ready` is not cancelled: the access completes and `ready` still pulses once, which the requester ignores.
- The non-owner port's `ready` is 0 in every state.

## Timing
- Reset values: state IDLE; `m_ce`, `m_we`, `i_ready`, `d_ready` = 0; `m_sel`, `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0; last-grant = fetch. `stall_o` follows its equation.
- Uncontended latency:
  - request seen in cycle N (IDLE)
  - memory driven in N+1 (ACCESS)
  - `ready` and data in N+2 (RESP)
- Interleaved fetch/data: one access is granted per RESP cycle, so a burst completes one access every 2 cycles.
- The losing port waits exactly one extra ACCESS/RESP pair; no port waits more than one pair when `DATA_PRIO`=0.
- Reset mid-operation:
  - A write whose ACCESS cycle coincides with `rst`=1 still lands at that edge, because `m_we` was already registered.
  - No `ready` is issued for that write.
  - All state returns to reset values on the next cycle.
- Simultaneous new request and `ready` on the same port in RESP are not possible, because the owner is excluded from re-arbitration.

## Test plan
- Reset: hold `rst` 2 cycles with both `ce`=1 → all outputs at reset values, `stall_o`=1, no `m_ce` until the cycle after `rst` falls.
- Single fetch: `i_ce`=1, `i_addr`=0x10, memory word 0x3C010001 → `m_ce`=1 with `m_addr`=0x10 and `m_sel`=4'hF in N+1; `i_ready`=1 with `i_rdata`=0x3C010001 in N+2; `stall_o` 1 in N and N+1, 0 in N+2.
- Store then load: `d_we`=1, `d_sel`=4'b0011, addr 0x40, data 0xAABBCCDD → `m_we`=1 with those values in N+1 and `d_ready` in N+2; a following load of 0x40 returns the lanes from the memory model (0x????CCDD).
- Contention, `DATA_PRIO`=1: both `ce` raised together → data served first, fetch `ACCESS` starts in the data RESP cycle, `i_ready` arrives 2 cycles after `d_ready`.
- Contention, `DATA_PRIO`=0: both held continuously for 8 accesses → grants strictly alternate, data first.
- Mid-op changes: `d_addr` changed after grant → memory sees the original address. `rst` asserted during ACCESS of a store → write lands, no `d_ready`, FSM in IDLE next cycle.
